hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage pipelined multicycle processor (IF/ID/EX/MEM/WB). It decides every cycle which pipeline registers load, hold or take a bubble. It resolves load-use and RAW hazards, flushes on taken branches, and sequences multicycle EX operations (mul/div) with an internal countdown. It sits beside the datapath in `maincode` and drives only enable, flush and forwarding-select lines.

## Interface
- REG_ADDR_W, 5, register index width
- MC_CNT_W, 4, width of multicycle extra-cycle count

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1  source actually read
- ex_rs1, ex_rs2  in  REG_ADDR_W  source registers of the instruction in EX
- ex_rd, mem_rd, wb_rd  in  REG_ADDR_W  destinations in EX/MEM/WB
- ex_wen, mem_wen, wb_wen  in  1  stage writes its rd
- ex_is_load  in  1  EX instruction is a load
- ex_mc_start  in  1  EX instruction is multicycle
- ex_mc_cycles  in  MC_CNT_W  extra EX cycles N required
- ex_branch_taken  in  1  branch resolved taken in EX
- pc_en, if_id_en  out  1  PC / IF-ID load enable
- if_id_flush, id_ex_flush  out  1  load a bubble into IF-ID / ID-EX
- ex_mem_bubble  out  1  load a bubble into EX-MEM, hold EX
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM
- mc_busy  out  1  FSM in MC_BUSY

## Operation
- Register 0 never creates a hazard and is never forwarded.
- FSM states: RUN, MC_BUSY. A 4-bit down-counter cnt is also kept.
- RUN with ex_mc_start=1 and N≠0: stall now, cnt←N-1, next state MC_BUSY.
- RUN with ex_mc_start=1 and N=0: no stall.
- MC_BUSY with cnt≠0: stall, cnt←cnt-1. ex_mc_start is ignored.
- MC_BUSY with cnt=0: no stall, next state RUN. The multicycle instruction occupies EX for exactly N+1 cycles with N stall cycles.
- MC stall outputs: pc_en=if_id_en=0, id_ex_flush=0 (ID-EX holds), ex_mem_bubble=1.
- Branch flush (ex_branch_taken, RUN only): if_id_flush=id_ex_flush=1, pc_en=1.
- Load-use stall: ex_is_load & ex_wen & ex_rd≠0 & ex_rd matches a used id_rs. Outputs: pc_en=if_id_en=0, id_ex_flush=1.
- Priority: reset > MC stall > branch flush > data stall.
- A branch and ex_mc_start in the same cycle is a protocol violation. The branch wins and MC_BUSY is not entered.
- Idle outputs: pc_en=if_id_en=1, all flushes and ex_mem_bubble 0.

## Timing
- All control outputs are combinational from inputs and registered state, valid in the same cycle. Only state and cnt are registered.
- While reset=1: pc_en=if_id_en=0, if_id_flush=id_ex_flush=ex_mem_bubble=1, fwd_a=fwd_b=00, mc_busy=0. The next edge sets state=RUN and cnt=0.
- Reset asserted in MC_BUSY aborts the countdown at that edge.
- mc_busy rises on the edge after the start cycle and falls on the edge after the cnt=0 cycle.

## Configuration
- FORWARDING_EN defined:
  - fwd_x=10 if mem_wen & mem_rd≠0 & mem_rd==ex_rsx.
  - Otherwise fwd_x=01 if the same condition holds for WB.
  - Otherwise fwd_x=00.
  - Only load-use data stalls occur.
- FORWARDING_EN undefined:
  - fwd_a=fwd_b=00 constant.
  - A data stall occurs whenever a used id_rs matches a writing, nonzero ex_rd, mem_rd or wb_rd. The register file has no write-through.

## Structure
- Package hazard_pkg holds:
  - state enum (RUN, MC_BUSY)
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_ZERO
- Sub-module fwd_sel: combinational per-operand forwarding select, instantiated twice (operands a and b). It is present only under FORWARDING_EN.

## Test plan
- Reset for 2 cycles, then release. Required: reset outputs as listed; first cycle after release pc_en=1, mc_busy=0.
- ex_mc_start=1, N=3 for 4 cycles:
  - exactly 3 cycles of pc_en=0 and ex_mem_bubble=1, starting in the start cycle
  - mc_busy high for 3 cycles
  - pc_en=1 in the 4th cycle
- Load in EX with ex_rd=5, ID uses rs2=5: one cycle of pc_en=0, id_ex_flush=1, then resume. Repeat with ex_rd=0: no stall.
- ex_branch_taken with a simultaneous load-use match: if_id_flush=id_ex_flush=1, pc_en=1, no stall.
- FORWARDING_EN: mem_rd=wb_rd=7, both writing, ex_rs1=7 → fwd_a=10. mem_wen=0 → fwd_a=01. Undefined macro, wb_rd=7 matches id_rs1 → stall.
- Reset asserted in the 2nd cycle of an N=5 MC op: next cycle state RUN, mc_busy=0, no residual stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional build macro: FORWARDING_EN (see hazard_ctrl.sv).
package hazard_pkg;

  // Multicycle sequencing states.
  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

  // EX operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Hard-wired zero register: never a hazard source, never forwarded.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select. MEM is the younger producer and wins over WB.
// Only instantiated when FORWARDING_EN is defined.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_wen,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_wen,
  output logic [1:0]            fwd
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_wen && (mem_rd != REG_ADDR_W'(REG_ZERO)) && (mem_rd == ex_rs);
  assign wb_hit  = wb_wen  && (wb_rd  != REG_ADDR_W'(REG_ZERO)) && (wb_rd  == ex_rs);

  // Pick the youngest matching producer, falling back to the register file.
  always_comb begin
    fwd = FWD_RF;
    if (mem_hit)     fwd = FWD_MEM;
    else if (wb_hit) fwd = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the five-stage pipeline.
// Resolves multicycle EX stalls, taken-branch flushes and data hazards, and
// drives the EX operand forwarding selects.
// Build macro FORWARDING_EN: when defined, MEM/WB results are forwarded to EX
// and only load-use hazards stall; when undefined, forwarding selects are tied
// to the register file and any pending write to a used ID source stalls.
// Priority of actions: reset > multicycle stall > branch flush > data stall.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MC_CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  ex_wen,
  input  logic                  mem_wen,
  input  logic                  wb_wen,
  input  logic                  ex_is_load,
  input  logic                  ex_mc_start,
  input  logic [MC_CNT_W-1:0]   ex_mc_cycles,
  input  logic                  ex_branch_taken,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mc_busy
);

  state_e                state_q, state_d;
  logic [MC_CNT_W-1:0]   cnt_q, cnt_d;

  logic mc_enter;
  logic mc_stall;
  logic br_flush;
  logic data_stall;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  // True when a writing, nonzero destination feeds a source read in ID.
  function automatic logic id_uses(input logic [REG_ADDR_W-1:0] rd, input logic wen);
    id_uses = wen && (rd != REG_ADDR_W'(REG_ZERO)) &&
              ((id_rs1_used && (id_rs1 == rd)) || (id_rs2_used && (id_rs2 == rd)));
  endfunction

  // A branch in the same cycle as a multicycle start wins; MC_BUSY is not entered.
  assign mc_enter = (state_q == RUN) && ex_mc_start && !ex_branch_taken &&
                    (ex_mc_cycles != '0);
  assign mc_stall = mc_enter || ((state_q == MC_BUSY) && (cnt_q != '0));
  assign br_flush = (state_q == RUN) && ex_branch_taken;
  assign mc_busy  = !reset && (state_q == MC_BUSY);

`ifdef FORWARDING_EN
  // Results in MEM/WB are forwarded, so only a load still in EX forces a stall.
  assign data_stall = ex_is_load && id_uses(ex_rd, ex_wen);

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_rs   (ex_rs1),
    .mem_rd  (mem_rd),
    .mem_wen (mem_wen),
    .wb_rd   (wb_rd),
    .wb_wen  (wb_wen),
    .fwd     (fwd_a_raw)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_rs   (ex_rs2),
    .mem_rd  (mem_rd),
    .mem_wen (mem_wen),
    .wb_rd   (wb_rd),
    .wb_wen  (wb_wen),
    .fwd     (fwd_b_raw)
  );
`else
  // No bypass and no register-file write-through: wait until the writer retires.
  assign data_stall = id_uses(ex_rd, ex_wen) || id_uses(mem_rd, mem_wen) ||
                      id_uses(wb_rd, wb_wen);
  assign fwd_a_raw  = FWD_RF;
  assign fwd_b_raw  = FWD_RF;

  // EX source indices only matter for forwarding.
  logic unused_ex_rs;
  assign unused_ex_rs = ^{ex_rs1, ex_rs2};
`endif

  assign fwd_a = reset ? FWD_RF : fwd_a_raw;
  assign fwd_b = reset ? FWD_RF : fwd_b_raw;

  // Pipeline register enables/flushes, highest-priority action first.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    if (reset) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (mc_stall) begin
      // Front end and ID-EX hold while EX keeps the multicycle op.
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (br_flush) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (data_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Next-state and countdown for multicycle EX sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mc_enter) begin
          state_d = MC_BUSY;
          cnt_d   = ex_mc_cycles - MC_CNT_W'(1);
        end
      end
      MC_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - MC_CNT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; reset aborts any countdown in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Inputs change just after the falling edge;
// combinational outputs are checked 1ns later, well before the next rising edge.
// Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_bubble, mc_busy}
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2;
  logic       id_rs1_used, id_rs2_used;
  logic [4:0] ex_rs1, ex_rs2;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_wen, mem_wen, wb_wen;
  logic       ex_is_load;
  logic       ex_mc_start;
  logic [3:0] ex_mc_cycles;
  logic       ex_branch_taken;
  logic       pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_bubble, mc_busy;
  logic [1:0] fwd_a, fwd_b;

  int total;
  int bad;

  localparam logic [5:0] O_RESET = 6'b001110;
  localparam logic [5:0] O_IDLE  = 6'b110000;
  localparam logic [5:0] O_MC0   = 6'b000010; // start cycle, still RUN
  localparam logic [5:0] O_MC    = 6'b000011; // stalling in MC_BUSY
  localparam logic [5:0] O_MCEND = 6'b110001; // last EX cycle, no stall
  localparam logic [5:0] O_LU    = 6'b000100;
  localparam logic [5:0] O_BR    = 6'b111100;

  hazard_ctrl #(.REG_ADDR_W(5), .MC_CNT_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_rd           (ex_rd),
    .mem_rd          (mem_rd),
    .wb_rd           (wb_rd),
    .ex_wen          (ex_wen),
    .mem_wen         (mem_wen),
    .wb_wen          (wb_wen),
    .ex_is_load      (ex_is_load),
    .ex_mc_start     (ex_mc_start),
    .ex_mc_cycles    (ex_mc_cycles),
    .ex_branch_taken (ex_branch_taken),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_bubble   (ex_mem_bubble),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .mc_busy         (mc_busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: return all pipeline inputs to a quiet state.
  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_wen = 1'b0; mem_wen = 1'b0; wb_wen = 1'b0; ex_is_load = 1'b0;
    ex_mc_start = 1'b0; ex_mc_cycles = '0; ex_branch_taken = 1'b0;
  endtask

  // Advance to the drive point of the next cycle.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Checks after inputs settle.
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    #1;
    obs = {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_bubble, mc_busy};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b);
    total++;
    assert ({fwd_a, fwd_b} === {exp_a, exp_b}) else begin
      bad++;
      $error("FAIL %s observed=%b/%b expected=%b/%b", tag, fwd_a, fwd_b, exp_a, exp_b);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_inputs();
    reset = 1'b1;

    // Reset held for two cycles.
    next_cycle(); chk_ctl("reset_c0", O_RESET); chk_fwd("reset_fwd0", 2'b00, 2'b00);
    next_cycle(); chk_ctl("reset_c1", O_RESET); chk_fwd("reset_fwd1", 2'b00, 2'b00);
    next_cycle(); reset = 1'b0; chk_ctl("post_reset", O_IDLE);

    // Multicycle op N=3, start held for four cycles.
    next_cycle(); ex_mc_start = 1'b1; ex_mc_cycles = 4'd3; chk_ctl("mc3_c0", O_MC0);
    next_cycle(); chk_ctl("mc3_c1", O_MC);
    next_cycle(); chk_ctl("mc3_c2", O_MC);
    next_cycle(); chk_ctl("mc3_c3", O_MCEND);
    next_cycle(); clear_inputs(); chk_ctl("mc3_after", O_IDLE);

    // N=0: no stall, MC_BUSY not entered.
    next_cycle(); ex_mc_start = 1'b1; ex_mc_cycles = 4'd0; chk_ctl("mc0_c0", O_IDLE);
    next_cycle(); clear_inputs(); chk_ctl("mc0_c1", O_IDLE);

    // N=1: one stall cycle.
    next_cycle(); ex_mc_start = 1'b1; ex_mc_cycles = 4'd1; chk_ctl("mc1_c0", O_MC0);
    next_cycle(); chk_ctl("mc1_c1", O_MCEND);
    next_cycle(); clear_inputs(); chk_ctl("mc1_after", O_IDLE);

    // Load-use on rs2.
    next_cycle();
    ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    chk_ctl("load_use", O_LU);
    next_cycle(); ex_is_load = 1'b0; ex_wen = 1'b0; ex_rd = 5'd0; chk_ctl("load_use_resume", O_IDLE);

    // Load to r0 never stalls.
    next_cycle(); ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    chk_ctl("load_r0", O_IDLE);

    // Matching index but source not read: no stall.
    next_cycle(); ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b0; chk_ctl("load_unused_src", O_IDLE);

    // Branch with a simultaneous load-use match: flush wins, no stall.
    next_cycle(); id_rs2_used = 1'b1; ex_branch_taken = 1'b1; chk_ctl("branch_over_lu", O_BR);

    // Branch with a simultaneous multicycle start: branch wins, no MC_BUSY.
    next_cycle(); clear_inputs(); ex_branch_taken = 1'b1; ex_mc_start = 1'b1; ex_mc_cycles = 4'd3;
    chk_ctl("branch_over_mc", O_BR);
    next_cycle(); clear_inputs(); chk_ctl("branch_over_mc_next", O_IDLE);

    // Forwarding selects with MEM and WB both writing r7.
    next_cycle(); mem_rd = 5'd7; wb_rd = 5'd7; mem_wen = 1'b1; wb_wen = 1'b1; ex_rs1 = 5'd7;
`ifdef FORWARDING_EN
    #1; chk_fwd("fwd_mem", 2'b10, 2'b00);
    next_cycle(); mem_wen = 1'b0; #1; chk_fwd("fwd_wb", 2'b01, 2'b00);
    next_cycle(); ex_rs2 = 5'd7; mem_wen = 1'b1; #1; chk_fwd("fwd_both", 2'b10, 2'b10);
    next_cycle(); mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0; #1;
    chk_fwd("fwd_r0", 2'b00, 2'b00);
    // WB write to a used ID source is bypassed: no stall.
    next_cycle(); clear_inputs(); wb_rd = 5'd7; wb_wen = 1'b1; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    chk_ctl("wb_match_no_stall", O_IDLE);
`else
    #1; chk_fwd("fwd_off_a", 2'b00, 2'b00);
    // No forwarding: WB write to a used ID source stalls.
    next_cycle(); clear_inputs(); wb_rd = 5'd7; wb_wen = 1'b1; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    chk_ctl("wb_match_stall", O_LU);
    next_cycle(); wb_rd = 5'd0; id_rs1 = 5'd0; mem_rd = 5'd9; mem_wen = 1'b1; id_rs2 = 5'd9; id_rs2_used = 1'b1;
    chk_ctl("mem_match_stall", O_LU);
    next_cycle(); clear_inputs(); ex_rd = 5'd3; ex_wen = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    chk_ctl("ex_alu_match_stall", O_LU);
`endif

    // Reset in the second cycle of an N=5 op aborts the countdown.
    next_cycle(); clear_inputs(); ex_mc_start = 1'b1; ex_mc_cycles = 4'd5; chk_ctl("mc5_c0", O_MC0);
    next_cycle(); chk_ctl("mc5_c1", O_MC);
    next_cycle(); reset = 1'b1; chk_ctl("mc5_reset", O_RESET);
    next_cycle(); reset = 1'b0; clear_inputs(); chk_ctl("mc5_after_reset", O_IDLE);
    next_cycle(); chk_ctl("mc5_after_reset2", O_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
